// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared state encoding and default 2x2 core chain geometry
package fpga_cfg_pkg;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLB_SHIFT  = 2'd1,
    CONN_SHIFT = 2'd2,
    DONE       = 2'd3
  } cfg_state_e;
  localparam int CFG_WORD_WIDTH     = 8;
  localparam int CLB_CHAIN_LEN_2X2  = 72;
  localparam int CONN_CHAIN_LEN_2X2 = 320;
  localparam int CFG_CNT_WIDTH      = 16;
endpackage

// File: rtl/cfg_word_serializer.sv
// cfg_word_serializer: one-word shifter emitting two clk cycles per bit with a registered scan clock
module cfg_word_serializer #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic                  sel_conn_i,
  input  logic                  cnt_last_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  output logic                  full_o,
  output logic                  scan_clk_o,
  output logic                  clb_data_o,
  output logic                  conn_data_o
);
  localparam int IW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  logic [WORD_WIDTH-1:0] word_q, word_d, word_sh;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  full_q, full_d, sclk_q, sclk_d, clb_q, clb_d, conn_q, conn_d, last;
  assign word_sh = word_q >> 1;
  // a word ends after its top bit or as soon as the chain is full; leftover bits are dropped
  assign last = sclk_q && (idx_q == IW'(WORD_WIDTH - 1) || cnt_last_i);
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    full_d = full_q;
    sclk_d = sclk_q;
    clb_d  = clb_q;
    conn_d = conn_q;
    if (clr_i) begin
      full_d = 1'b0;
      sclk_d = 1'b0;
      clb_d  = 1'b0;
      conn_d = 1'b0;
    end else if (load_i) begin
      word_d = word_i;
      idx_d  = '0;
      full_d = 1'b1;
      sclk_d = 1'b0;
      clb_d  = sel_conn_i ? 1'b0 : word_i[0];
      conn_d = sel_conn_i ? word_i[0] : 1'b0;
    end else if (full_q && !sclk_q) begin
      sclk_d = 1'b1;
    end else if (sclk_q) begin
      sclk_d = 1'b0;
      full_d = !last;
      if (!last) begin
        word_d = word_sh;
        idx_d  = idx_q + IW'(1);
        clb_d  = sel_conn_i ? 1'b0 : word_sh[0];
        conn_d = sel_conn_i ? word_sh[0] : 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
      sclk_q <= 1'b0;
      clb_q  <= 1'b0;
      conn_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      full_q <= full_d;
      sclk_q <= sclk_d;
      clb_q  <= clb_d;
      conn_q <= conn_d;
    end
  end
  assign full_o      = full_q;
  assign scan_clk_o  = sclk_q;
  assign clb_data_o  = clb_q;
  assign conn_data_o = conn_q;
endmodule

// File: rtl/fpga_config_loader.sv
// fpga_config_loader: streams host words onto the core CLB chain then connection chain
// and keeps the fabric in reset until both chains are loaded
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int WORD_WIDTH     = CFG_WORD_WIDTH,
  parameter int CLB_CHAIN_LEN  = CLB_CHAIN_LEN_2X2,
  parameter int CONN_CHAIN_LEN = CONN_CHAIN_LEN_2X2,
  parameter int CNT_WIDTH      = CFG_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  scan_clk,
  output logic                  clb_scan_in,
  output logic                  clb_scan_en,
  output logic                  conn_scan_in,
  output logic                  conn_scan_en,
  output logic                  fabric_hold,
  output logic                  busy,
  output logic                  done
);
  cfg_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 clr, load, full, cnt_last, shifting;
  logic                 busy_q, done_q, hold_q, clb_en_q, conn_en_q;
  assign shifting = state_q == CLB_SHIFT || state_q == CONN_SHIFT;
  assign in_ready = shifting && !full;
  assign load     = in_valid && in_ready;
  assign cnt_last = cnt_q == CNT_WIDTH'(1);
  // scan_clk high is the bit-commit phase, so it doubles as the counter tick
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = CLB_SHIFT;
        cnt_d   = CNT_WIDTH'(CLB_CHAIN_LEN);
      end
      CLB_SHIFT, CONN_SHIFT: if (scan_clk) begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_last) begin
          clr     = 1'b1;
          state_d = (state_q == CLB_SHIFT) ? CONN_SHIFT : DONE;
          cnt_d   = (state_q == CLB_SHIFT) ? CNT_WIDTH'(CONN_CHAIN_LEN) : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hold_q    <= 1'b1;
      clb_en_q  <= 1'b0;
      conn_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= state_d == CLB_SHIFT || state_d == CONN_SHIFT;
      done_q    <= state_d == DONE;
      hold_q    <= state_d != DONE;
      clb_en_q  <= state_d == CLB_SHIFT;
      conn_en_q <= state_d == CONN_SHIFT;
    end
  end
  cfg_word_serializer #(.WORD_WIDTH(WORD_WIDTH)) u_ser (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (clr),
    .load_i     (load),
    .sel_conn_i (state_q == CONN_SHIFT),
    .cnt_last_i (cnt_last),
    .word_i     (in_data),
    .full_o     (full),
    .scan_clk_o (scan_clk),
    .clb_data_o (clb_scan_in),
    .conn_data_o(conn_scan_in)
  );
  assign busy         = busy_q;
  assign done         = done_q;
  assign fabric_hold  = hold_q;
  assign clb_scan_en  = clb_en_q;
  assign conn_scan_en = conn_en_q;
endmodule

// File: tb/tb_fpga_config_loader.sv
// tb_fpga_config_loader: directed passes on a 10/12-bit chain loader with hand-computed chain images
module tb_fpga_config_loader;
  logic       clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, scan_clk, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en;
  logic       fabric_hold, busy, done;
  int         checks = 0, fails = 0, cyc = 0, nhigh = 0, last_hi = -1, done_cyc = -1;
  int         hi_t[8];
  bit         clb_cap[$], conn_cap[$];
  logic       prev_clb = 1'b0, prev_conn = 1'b0, prev_done = 1'b0;

  fpga_config_loader #(.WORD_WIDTH(8), .CLB_CHAIN_LEN(10), .CONN_CHAIN_LEN(12), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .scan_clk(scan_clk), .clb_scan_in(clb_scan_in), .clb_scan_en(clb_scan_en),
    .conn_scan_in(conn_scan_in), .conn_scan_en(conn_scan_en), .fabric_hold(fabric_hold),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("en_exclusive", {31'd0, clb_scan_en & conn_scan_en}, 32'd0);
    if (scan_clk) begin
      if (nhigh < 8) hi_t[nhigh] = cyc;
      nhigh++;
      last_hi = cyc;
      if (clb_scan_en) clb_cap.push_back(clb_scan_in);
      if (conn_scan_en) conn_cap.push_back(conn_scan_in);
      chk("clb_stable_high", {31'd0, clb_scan_in}, {31'd0, prev_clb});
      chk("conn_stable_high", {31'd0, conn_scan_in}, {31'd0, prev_conn});
    end
    if (done && !prev_done) done_cyc = cyc;
    prev_clb  = clb_scan_in;
    prev_conn = conn_scan_in;
    prev_done = done;
  end

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v[i] = q[i];
    return v;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_scan_clk"}, {31'd0, scan_clk}, 32'd0);
    chk({tag, "_clb_in"}, {31'd0, clb_scan_in}, 32'd0);
    chk({tag, "_conn_in"}, {31'd0, conn_scan_in}, 32'd0);
    chk({tag, "_ens"}, {30'd0, clb_scan_en, conn_scan_en}, 32'd0);
    chk({tag, "_hold"}, {31'd0, fabric_hold}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_pass(input logic [31:0] w, input logic [31:0] clb_exp, input logic [31:0] conn_exp,
                          input bit do_stall, input bit poke, input bit timing);
    int wi = 0, stalled = 0, t_acc = -1, t_rdy = -1;
    bit poked = 0;
    @(negedge clk);
    start = 1'b1;
    clb_cap.delete();
    conn_cap.delete();
    nhigh = 0;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_done_clr", {31'd0, done}, 32'd0);
    chk("start_hold", {31'd0, fabric_hold}, 32'd1);
    for (int i = 0; i < 400; i++) begin
      if (done) break;
      start = 1'b0;
      if (t_acc >= 0 && t_rdy < 0 && in_ready) t_rdy = cyc;
      if (poke && conn_scan_en && !poked) begin
        start = 1'b1;
        poked = 1;
      end
      if (do_stall && wi == 1 && in_ready && stalled < 5) begin
        in_valid = 1'b0;
        stalled++;
        chk("stall_sclk", {31'd0, scan_clk}, 32'd0);
        chk("stall_en", {31'd0, clb_scan_en}, 32'd1);
        chk("stall_hold_data", {31'd0, clb_scan_in}, {31'd0, w[7]});
      end else begin
        in_valid = wi < 4;
        in_data  = (wi < 4) ? w[wi*8 +: 8] : 8'h00;
        if (in_valid && in_ready) begin
          if (t_acc < 0) t_acc = cyc;
          wi++;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("pass_done", {31'd0, done}, 32'd1);
    chk("pass_hold", {31'd0, fabric_hold}, 32'd0);
    chk("pass_busy", {31'd0, busy}, 32'd0);
    chk("pass_ready", {31'd0, in_ready}, 32'd0);
    chk("clb_bits", clb_cap.size(), 32'd10);
    chk("conn_bits", conn_cap.size(), 32'd12);
    chk("clb_image", pack(clb_cap), clb_exp);
    chk("conn_image", pack(conn_cap), conn_exp);
    chk("high_phases", nhigh, 32'd22);
    chk("done_latency", done_cyc, last_hi + 1);
    if (do_stall) chk("stall_count", stalled, 32'd5);
    if (timing) begin
      for (int k = 0; k < 8; k++) chk($sformatf("rise_%0d", k), hi_t[k], t_acc + 2 + 2*k);
      chk("ready_again", t_rdy, t_acc + 17);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("por");
    reset = 1'b1;
    @(negedge clk);
    run_pass({8'h0F, 8'h3C, 8'h02, 8'hA5}, 32'h2A5, 32'hF3C, 0, 0, 0);
    run_pass({8'h0F, 8'h3C, 8'h02, 8'hA5}, 32'h2A5, 32'hF3C, 1, 0, 0);
    run_pass({8'h55, 8'hAA, 8'h00, 8'hFF}, 32'h0FF, 32'h5AA, 0, 0, 1);
    run_pass({8'h0F, 8'h3C, 8'h02, 8'hA5}, 32'h2A5, 32'hF3C, 0, 1, 0);
    @(negedge clk);
    start = 1'b1;
    nhigh = 0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hA5;
    for (int i = 0; i < 50 && nhigh < 3; i++) @(negedge clk);
    chk("mid_reach", {31'd0, nhigh >= 3}, 32'd1);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_clb_en", {31'd0, clb_scan_en}, 32'd1);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    reset = 1'b1;
    run_pass({8'h0F, 8'h3C, 8'h02, 8'hA5}, 32'h2A5, 32'hF3C, 0, 0, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
